// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
// Imported by the interface, the address generator and the top module.
// Holds the FSM state encoding so every file agrees on it.
package mac_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ACC_W_DEF      = 16;
  localparam int MAX_LEN_DEF    = 256;
  localparam int MEM_ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bundle of command, RAM, MAC and result signals for the dot-product sequencer.
// master = surrounding system (command source, RAMs, MAC, result sink).
// slave  = the sequencer itself.
interface mac_dot_sequencer_if
  import mac_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  // command
  logic                  start;
  logic                  abort;
  logic [LEN_W-1:0]      vec_len;
  logic [MEM_ADDR_W-1:0] data_base;
  logic [MEM_ADDR_W-1:0] weight_base;
  // RAM read port
  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] data_addr;
  logic [MEM_ADDR_W-1:0] weight_addr;
  logic [DATA_W-1:0]     data_rdata;
  logic [DATA_W-1:0]     weight_rdata;
  // MAC control
  logic                  mac_clear;
  logic                  mac_enable;
  logic [DATA_W-1:0]     mac_data;
  logic [DATA_W-1:0]     mac_weight;
  logic [ACC_W-1:0]      mac_result;
  // result port and status
  logic [ACC_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, vec_len, data_base, weight_base,
    output data_rdata, weight_rdata, mac_result, out_ready,
    input  mem_rd_en, data_addr, weight_addr, mac_clear, mac_enable,
    input  mac_data, mac_weight, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, abort, vec_len, data_base, weight_base,
    input  data_rdata, weight_rdata, mac_result, out_ready,
    output mem_rd_en, data_addr, weight_addr, mac_clear, mac_enable,
    output mac_data, mac_weight, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Address generator: latches bases and clamped length, counts elements, flags the last one.
// Latency: addresses are combinational from latched state; counter steps once per STREAM cycle.
// Backpressure: none; addresses read as 0 whenever no read is being issued.
module mac_seq_addr_gen
  import mac_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter int LEN_W      = $clog2(MAX_LEN) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic                  first_i,
  input  logic                  step_i,
  input  logic                  rd_en_i,
  input  logic [LEN_W-1:0]      vec_len_i,
  input  logic [MEM_ADDR_W-1:0] data_base_i,
  input  logic [MEM_ADDR_W-1:0] weight_base_i,
  output logic                  len_zero_o,
  output logic                  last_o,
  output logic [MEM_ADDR_W-1:0] data_addr_o,
  output logic [MEM_ADDR_W-1:0] weight_addr_o
);

  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      k_q, k_d;
  logic [MEM_ADDR_W-1:0] dbase_q, dbase_d;
  logic [MEM_ADDR_W-1:0] wbase_q, wbase_d;
  logic [MEM_ADDR_W-1:0] offset;

  assign len_zero_o = (len_q == '0);
  assign last_o     = (k_q == len_q - LEN_W'(1));

  // Offset 0 is the first read issued from CLEAR; in STREAM element k prefetches k+1.
  // Additions are MEM_ADDR_W wide so the address wraps past the top of the RAM.
  assign offset        = first_i ? '0 : MEM_ADDR_W'(k_q) + MEM_ADDR_W'(1);
  assign data_addr_o   = rd_en_i ? dbase_q + offset : '0;
  assign weight_addr_o = rd_en_i ? wbase_q + offset : '0;

  // Latch the command on load (clamping oversize lengths) and advance the element index.
  always_comb begin
    len_d   = len_q;
    k_d     = k_q;
    dbase_d = dbase_q;
    wbase_d = wbase_q;
    if (load_i) begin
      len_d   = (vec_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len_i;
      k_d     = '0;
      dbase_d = data_base_i;
      wbase_d = weight_base_i;
    end else if (step_i && !last_o) begin
      k_d = k_q + LEN_W'(1);
    end
  end

  // Command and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q   <= '0;
      k_q     <= '0;
      dbase_q <= '0;
      wbase_q <= '0;
    end else begin
      len_q   <= len_d;
      k_q     <= k_d;
      dbase_q <= dbase_d;
      wbase_q <= wbase_d;
    end
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: reads vec_len operand pairs, streams them into the MAC, captures acc+bias.
// Latency: out_valid rises len+2 edges after start is sampled (2 for len==0).
// Backpressure: out_data/out_valid held until out_ready; done pulses the cycle after acceptance.
// Optional MAC_SEQ_RELU_EN: negative results are captured as 0 (timing unchanged).
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
  input logic               clock,
  input logic               reset_n,
  mac_dot_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             abort_clr_q, abort_clr_d;
  logic             load;
  logic             len_zero;
  logic             last_elem;
  logic             issue_rd;
  logic [ACC_W-1:0] capture_val;
  logic [DATA_W-1:0] mac_data_w;
  logic [DATA_W-1:0] mac_weight_w;

  mac_seq_addr_gen #(
    .MAX_LEN    (MAX_LEN),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_addr_gen (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_i        (load),
    .first_i       (state_q == CLEAR),
    .step_i        (state_q == STREAM),
    .rd_en_i       (issue_rd),
    .vec_len_i     (bus.vec_len),
    .data_base_i   (bus.data_base),
    .weight_base_i (bus.weight_base),
    .len_zero_o    (len_zero),
    .last_o        (last_elem),
    .data_addr_o   (bus.data_addr),
    .weight_addr_o (bus.weight_addr)
  );

  // One read per element: the first from CLEAR, the rest prefetched during STREAM.
  assign issue_rd = ((state_q == CLEAR) && !len_zero) || ((state_q == STREAM) && !last_elem);

`ifdef MAC_SEQ_RELU_EN
  assign capture_val = bus.mac_result[ACC_W-1] ? '0 : bus.mac_result;
`else
  assign capture_val = bus.mac_result;
`endif

  // Operands forwarded only while enabled so idle/reset outputs stay at zero.
  assign mac_data_w   = (state_q == STREAM) ? bus.data_rdata   : '0;
  assign mac_weight_w = (state_q == STREAM) ? bus.weight_rdata : '0;

  assign bus.mem_rd_en  = issue_rd;
  assign bus.mac_enable = (state_q == STREAM);
  // The abort clear is registered, so it lands in IDLE and never overlaps mac_enable.
  assign bus.mac_clear  = (state_q == CLEAR) || abort_clr_q;
  assign bus.mac_data   = mac_data_w;
  assign bus.mac_weight = mac_weight_w;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

  // Next-state and result-register logic; abort overrides every transition.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    abort_clr_d = bus.abort;
    load        = 1'b0;
    if (bus.abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            load    = 1'b1;
            state_d = CLEAR;
          end
        end
        CLEAR:   state_d = len_zero ? CAPTURE : STREAM;
        STREAM:  if (last_elem) state_d = CAPTURE;
        CAPTURE: begin
          out_data_d  = capture_val;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      abort_clr_q <= abort_clr_d;
    end
  end

endmodule
